// File: rtl/isa_pkg.sv
// Shared definitions for the 16-bit ISA core: opcodes, field widths, fetch state and queue entry.
package isa_pkg;

  localparam logic [2:0] OPC_ADD  = 3'b000;
  localparam logic [2:0] OPC_ADDI = 3'b001;
  localparam logic [2:0] OPC_BEQ  = 3'b100;
  localparam logic [2:0] OPC_SW   = 3'b101;
  localparam logic [2:0] OPC_LW   = 3'b110;
  localparam logic [2:0] OPC_JMP  = 3'b111;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned OPC_W     = 3;
  localparam int unsigned JMP_TGT_W = 13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [OPC_W-1:0] opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

  // Jump targets live in the low 8K words; upper PC bits are forced to zero.
  function automatic logic [ADDR_W-1:0] jmp_target(input logic [INSTR_W-1:0] instr);
    return {{(ADDR_W - JMP_TGT_W){1'b0}}, instr[JMP_TGT_W-1:0]};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {PC, instruction} entries with flush and same-cycle push/pop.
module fetch_queue
  import isa_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic         full_o
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(QDEPTH);

  fetch_entry_t    mem_q [QDEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CntFull);
  assign head_o  = mem_q[rd_ptr_q];

  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && valid_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, fetches from combinational instruction memory, folds jmp, and queues words for decode.
module fetch_sequencer
  import isa_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 512,
  parameter int unsigned QDEPTH    = 2,
  parameter logic [2:0]  JMP_OPC   = OPC_JMP
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] start_pc_i,
  output logic [15:0] address_o,
  input  logic [15:0] instruction_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_instr_o,
  output logic [15:0] out_pc_o,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        busy_o,
  output logic        fault_o
);

  localparam logic [16:0] MemLimit = 17'(MEM_DEPTH);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;

  logic         q_flush, q_push, q_pop, q_valid, q_full;
  fetch_entry_t q_head, q_in;
  logic         has_space, pc_fault, is_jmp;

  assign address_o = pc_q;
  assign pc_fault  = ({1'b0, pc_q} >= MemLimit);
  assign is_jmp    = (opcode(instruction_i) == JMP_OPC);
  assign q_in      = '{pc: pc_q, instr: instruction_i};
  assign q_pop     = q_valid && out_ready_i;
  // Room exists if not full now or if the head leaves this cycle.
  assign has_space = !q_full || q_pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    q_flush = 1'b0;
    q_push  = 1'b0;
    if (start_i) begin
      q_flush = 1'b1;
      pc_d    = start_pc_i;
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (redirect_i) begin
        q_flush = 1'b1;
        pc_d    = redirect_pc_i;
      end else if (has_space) begin
        if (pc_fault) begin
          state_d = S_FAULT;
        end else if (is_jmp) begin
          pc_d = jmp_target(instruction_i);
        end else begin
          q_push = 1'b1;
          pc_d   = pc_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_fetch_queue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (q_flush),
    .push_i      (q_push),
    .push_data_i (q_in),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .valid_o     (q_valid),
    .full_o      (q_full)
  );

  assign out_valid_o = q_valid;
  assign out_instr_o = q_head.instr;
  assign out_pc_o    = q_head.pc;
  assign busy_o      = (state_q == S_RUN);
  assign fault_o     = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard of expected {PC, instruction} entries.
module tb_fetch_sequencer;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] start_pc;
  logic [15:0] address;
  logic [15:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        busy;
  logic        fault;

  logic [15:0] mem [0:1023];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          bubbles;

  assign instruction = (address < 16'd1024) ? mem[address[9:0]] : 16'h0000;

  fetch_sequencer #(
    .MEM_DEPTH(512),
    .QDEPTH   (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .start_pc_i    (start_pc),
    .address_o     (address),
    .instruction_i (instruction),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_instr_o   (out_instr),
    .out_pc_o      (out_pc),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .busy_o        (busy),
    .fault_o       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] addi_word(input int i);
    return {3'b001, 13'(i)};
  endfunction

  task automatic expect_pc(input int pc);
    exp_t e;
    e.pc    = 16'(pc);
    e.instr = mem[pc];
    sb.push_back(e);
  endtask

  // Called at a negedge with out_ready=1: every valid head seen is accepted at the next posedge.
  task automatic drain(input int budget, output int nbub);
    exp_t e;
    bit   seen;
    nbub = 0;
    seen = 0;
    for (int c = 0; c < budget && sb.size() > 0; c++) begin
      if (out_valid) begin
        seen = 1;
        e = sb.pop_front();
        chk("head_pc", {16'h0, out_pc}, {16'h0, e.pc});
        chk("head_instr", {16'h0, out_instr}, {16'h0, e.instr});
      end else if (seen) begin
        nbub++;
      end
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic pulse_start(input logic [15:0] pc, input logic rdy);
    start     = 1'b1;
    start_pc  = pc;
    out_ready = rdy;
    @(negedge clk);
    start     = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = addi_word(i);
    mem[12] = 16'b111_0000_0000_01001;

    rst_n = 1'b0; start = 1'b0; start_pc = '0; out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;

    // Reset values
    #12;
    chk("rst_address", {16'h0, address}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_instr", {16'h0, out_instr}, 32'h0);
    chk("rst_pc", {16'h0, out_pc}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_valid", {31'h0, out_valid}, 32'h0);

    // Streaming from 0, jmp at 12 folds back to 9 with one bubble per loop
    pulse_start(16'd0, 1'b1);
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_valid", {31'h0, out_valid}, 32'h0);
    chk("start_address", {16'h0, address}, 32'h0);
    for (int p = 0; p < 12; p++) expect_pc(p);
    for (int p = 9; p < 12; p++) expect_pc(p);
    expect_pc(9);
    drain(40, bubbles);
    chk("jmp_bubbles", bubbles, 2);

    // Backpressure: two entries held, address stalls at 2
    pulse_start(16'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("bp_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_head_pc", {16'h0, out_pc}, 32'h0);
    chk("bp_address", {16'h0, address}, 32'h2);
    out_ready = 1'b1;
    for (int p = 0; p < 5; p++) expect_pc(p);
    drain(20, bubbles);
    chk("bp_bubbles", bubbles, 0);

    // Redirect while queue holds 5,6 (with ready asserted): 5,6 are dropped
    pulse_start(16'd5, 1'b0);
    repeat (4) @(negedge clk);
    chk("rd_head_pc", {16'h0, out_pc}, 32'h5);
    chk("rd_address", {16'h0, address}, 32'h7);
    redirect    = 1'b1;
    redirect_pc = 16'd17;
    out_ready   = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    chk("rd_valid_after", {31'h0, out_valid}, 32'h0);
    chk("rd_address_after", {16'h0, address}, 32'd17);
    for (int p = 17; p < 20; p++) expect_pc(p);
    drain(20, bubbles);

    // Memory-end fault
    pulse_start(16'd510, 1'b1);
    expect_pc(510);
    expect_pc(511);
    drain(20, bubbles);
    @(negedge clk);
    chk("flt_fault", {31'h0, fault}, 32'h1);
    chk("flt_busy", {31'h0, busy}, 32'h0);
    chk("flt_valid", {31'h0, out_valid}, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 16'd3;
    @(negedge clk);
    redirect = 1'b0;
    chk("flt_redirect_ignored", {16'h0, address}, 32'd512);
    chk("flt_sticky", {31'h0, fault}, 32'h1);
    pulse_start(16'd0, 1'b1);
    chk("flt_cleared", {31'h0, fault}, 32'h0);
    chk("flt_restart_busy", {31'h0, busy}, 32'h1);

    // Async reset mid-stream
    repeat (3) @(negedge clk);
    chk("ar_pre_valid", {31'h0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'h0, out_valid}, 32'h0);
    chk("ar_pc", {16'h0, out_pc}, 32'h0);
    chk("ar_instr", {16'h0, out_instr}, 32'h0);
    chk("ar_address", {16'h0, address}, 32'h0);
    chk("ar_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_idle_valid", {31'h0, out_valid}, 32'h0);
    chk("ar_idle_busy", {31'h0, busy}, 32'h0);
    pulse_start(16'd3, 1'b1);
    expect_pc(3);
    expect_pc(4);
    drain(10, bubbles);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
